pixel_rotate_map: RTL
=====================

# pixel_rotate_map

Parametrised raster-to-source address generator for the rotated-display path. It sweeps output pixel coordinates in raster order and rotates each about a programmable centre, using signed fixed-point sine/cosine from the LUT or CORDIC source. For each pixel it emits a frame-buffer read address and an in-range flag. Output uses a valid/ready stream with backpressure instead of a full-flag FIFO, and rotation coefficients are frame-coherent.

## Interface
- H_RES, 800: output columns per line
- V_RES, 480: output lines per frame
- COORD_W, 16: signed coordinate width
- TRIG_W, 9: signed coefficient width
- FRAC_W, 7: coefficient fraction bits; 1.0 = 2^FRAC_W = 128
- ADDR_W, 20: address width
- FLIP_V, 1: 1 = vertically flipped address, (V_RES-1-y)*H_RES+x
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- iENABLE  in  1  permits new pixels to enter the pipeline
- iCOS  in  TRIG_W  signed cos(theta)
- iSIN  in  TRIG_W  signed sin(theta)
- iCENTER_X  in  COORD_W  rotation centre column, unsigned
- iCENTER_Y  in  COORD_W  rotation centre row, unsigned
- oVALID  out  1  output beat valid
- iREADY  in  1  consumer accepts beat when oVALID&&iREADY
- oADDR  out  ADDR_W  source address; 0 when out of range
- oIN_RANGE  out  1  rotated coordinate lies inside H_RES x V_RES
- oFRAME_START  out  1  beat carries pixel (0,0)

## Operation
- Raster counter (col,row):
  - Starts at (0,0).
  - Advances only when a pixel enters stage 1.
  - col wraps H_RES-1 -> 0 and increments row; row wraps V_RES-1 -> 0.
- Pixel entry: a pixel enters when iENABLE=1 and the pipeline is not stalled.
- Shadow registers hold cos, sin, cx and cy.
  - They load from the inputs only on the cycle pixel (0,0) enters.
  - Mid-frame input changes have no effect until the next frame.
- Stage 1: dx = col - cx and dy = row - cy, signed COORD_W+1. Also registers the frame-start tag.
- Stage 2: four products dx*cos, dy*sin, dx*sin and dy*cos, each signed COORD_W+TRIG_W+1.
- Stage 3:
  - sx = dx*cos - dy*sin and sy = dx*sin + dy*cos, one extra bit each.
  - Round half-up: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W.
  - Add cx or cy to give x and y, signed COORD_W+2.
  - oIN_RANGE = (0<=x<H_RES)&&(0<=y<V_RES).
  - oADDR is the flipped or plain address when in range, else 0.
- Stall: a single global stall = oVALID && !iREADY freezes all stages, the counter and outputs.
- Bubbles: valid bits travel with data; an iENABLE low cycle inserts a bubble and holds the counter.
- Reset values:
  - col=row=0; all stage valids 0.
  - oVALID=0, oADDR=0, oIN_RANGE=0, oFRAME_START=0.
  - Shadow cos=2^FRAC_W, sin=0, cx=H_RES/2, cy=V_RES/2.

## Timing
- Latency: exactly 3 cycles from pixel entry to oVALID with no stall.
- Throughput: 1 pixel per cycle while iENABLE=1 and iREADY=1.
- Beat stability: while oVALID=1 and iREADY=0, oADDR, oIN_RANGE and oFRAME_START hold stable.
- Backpressure: no pixel is dropped or duplicated; every frame delivers exactly H_RES*V_RES beats.
- oFRAME_START: high for exactly one accepted beat per frame.
- Simultaneous entry of (0,0) and coefficient change: the new inputs apply to that frame.
- Reset mid-operation: in-flight beats are discarded; the next beat after reset is (0,0) with oFRAME_START=1.
- iENABLE deasserted mid-frame: the frame resumes from the held counter; no restart.

## Structure
- Package pixel_map_pkg holds:
  - default resolution constants
  - FRAC_W and the derived ONE = 2^FRAC_W
  - the rounding constant
  - coordinate/product width functions shared with the sine/cosine sources
- Sub-module pixel_raster_counter: col/row counter with advance enable, wrap and frame-start flag.
- Top level holds the shadow registers, the three-stage datapath and the stall logic.

## Test plan
- Identity, cos=128, sin=0, centre (400,240):
  - first beat (0,0): oADDR=383200, oIN_RANGE=1, oFRAME_START=1
  - beat (799,479): oADDR=799
- 90 degrees, cos=0, sin=128:
  - pixel (400,240): oADDR=191600
  - pixel (500,240): oADDR=111600
  - pixel (0,0): x=640, y=-160, oIN_RANGE=0, oADDR=0
- Random iREADY (50%) plus 5-cycle holds: beats stable while stalled; 384000 beats per frame; sequence matches the golden model.
- iSIN changed at pixel (10,100): rest of the frame uses old coefficients; first beat of the next frame uses new ones.
- RESET pulsed mid-frame: oVALID=0 next cycle; first beat after release is (0,0), oFRAME_START=1.
- iENABLE toggled every 3 cycles: no skipped coordinates; latency stays 3 cycles from entry.

Source files
------------

// File: rtl/pixel_map_pkg.sv
// pixel_map_pkg: shared constants and width helpers for the rotated-display
// address path and the sine/cosine sources that feed it.
//   - default raster resolution and coordinate/coefficient/address widths
//   - coefficient fixed-point format (fraction bits, 1.0, rounding constant)
//   - width functions so producers and consumers agree on signed sizes
package pixel_map_pkg;

    localparam int DEF_H_RES   = 800;
    localparam int DEF_V_RES   = 480;
    localparam int DEF_COORD_W = 16;
    localparam int DEF_TRIG_W  = 9;
    localparam int DEF_ADDR_W  = 20;

    // Coefficient format: signed Q(TRIG_W-FRAC_W).FRAC_W, 1.0 = 128
    localparam int COEF_FRAC_W = 7;
    localparam int COEF_ONE    = 1 << COEF_FRAC_W;
    localparam int COEF_RND    = 1 << (COEF_FRAC_W - 1);

    function automatic int one_of(input int frac_w);
        return 1 << frac_w;
    endfunction

    // Half-LSB added before the truncating shift gives round half-up
    function automatic int rnd_of(input int frac_w);
        return 1 << (frac_w - 1);
    endfunction

    // Signed difference of two unsigned coordinates
    function automatic int diff_w(input int coord_w);
        return coord_w + 1;
    endfunction

    // Signed difference times signed coefficient
    function automatic int prod_w(input int coord_w, input int trig_w);
        return coord_w + trig_w + 1;
    endfunction

    // Rotated coordinate after adding the centre back
    function automatic int xy_w(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/pixel_rotate_map_if.sv
// pixel_rotate_map_if: output beat stream of the rotate/address generator.
//   oVALID       beat valid
//   iREADY       consumer accepts the beat when oVALID && iREADY
//   oADDR        frame-buffer read address (0 when out of range)
//   oIN_RANGE    rotated coordinate lies inside the frame
//   oFRAME_START beat carries pixel (0,0)
interface pixel_rotate_map_if #(
    parameter int ADDR_W = 20
);
    logic              oVALID;
    logic              iREADY;
    logic [ADDR_W-1:0] oADDR;
    logic              oIN_RANGE;
    logic              oFRAME_START;

    modport master (output oVALID, oADDR, oIN_RANGE, oFRAME_START, input iREADY);
    modport slave  (input oVALID, oADDR, oIN_RANGE, oFRAME_START, output iREADY);
endinterface

// File: rtl/pixel_raster_counter.sv
// pixel_raster_counter: output raster position in scan order.
//   CLK, RESET   clock, synchronous active-high reset
//   advance      a pixel is taken from the current position this cycle
//   col, row     current position; wraps H_RES-1 -> 0, V_RES-1 -> 0
//   frame_start  current position is (0,0)
module pixel_raster_counter
    import pixel_map_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int CNT_W = DEF_COORD_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             advance,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_RES - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_RES - 1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign frame_start = (col == '0) && (row == '0);

endmodule

// File: rtl/pixel_rotate_map.sv
// pixel_rotate_map: sweeps output pixels in raster order, rotates each about
// a programmable centre and emits the frame-buffer source address.
//   CLK, RESET          clock, synchronous active-high reset
//   iENABLE             lets a new pixel enter the pipeline
//   iCOS, iSIN          signed coefficients, 1.0 = 2^FRAC_W
//   iCENTER_X/Y         rotation centre (unsigned)
//   bus (master)        oVALID/iREADY stream with oADDR, oIN_RANGE, oFRAME_START
// Three register stages: differences, products, sum/round/range/address.
// One global stall (beat presented but not taken) freezes everything.
module pixel_rotate_map
    import pixel_map_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COORD_W = DEF_COORD_W,
    parameter int TRIG_W  = DEF_TRIG_W,
    parameter int FRAC_W  = COEF_FRAC_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int FLIP_V  = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      iENABLE,
    input  logic signed [TRIG_W-1:0]  iCOS,
    input  logic signed [TRIG_W-1:0]  iSIN,
    input  logic        [COORD_W-1:0] iCENTER_X,
    input  logic        [COORD_W-1:0] iCENTER_Y,
    pixel_rotate_map_if.master        bus
);

    localparam int STAGES = 3;
    localparam int DIFF_W = diff_w(COORD_W);
    localparam int PROD_W = prod_w(COORD_W, TRIG_W);
    localparam int SUM_W  = PROD_W + 1;
    localparam int XY_W   = xy_w(COORD_W);
    localparam int ONE    = one_of(FRAC_W);
    localparam int RND    = rnd_of(FRAC_W);

    logic stall, enter;
    logic [STAGES:1] vld_pipe;

    assign stall = bus.oVALID && !bus.iREADY;
    assign enter = iENABLE && !stall;

    // Raster position
    logic [COORD_W-1:0] col, row;
    logic               first;

    pixel_raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .CNT_W (COORD_W)
    ) u_cnt (
        .CLK         (CLK),
        .RESET       (RESET),
        .advance     (enter),
        .col         (col),
        .row         (row),
        .frame_start (first)
    );

    // Frame-coherent coefficients: captured as (0,0) enters, and (0,0) itself
    // already uses the live inputs so a change on that cycle applies at once.
    logic signed [TRIG_W-1:0]  sh_cos, sh_sin;
    logic        [COORD_W-1:0] sh_cx, sh_cy;
    logic signed [TRIG_W-1:0]  cos_use, sin_use;
    logic        [COORD_W-1:0] cx_use, cy_use;

    assign cos_use = first ? iCOS      : sh_cos;
    assign sin_use = first ? iSIN      : sh_sin;
    assign cx_use  = first ? iCENTER_X : sh_cx;
    assign cy_use  = first ? iCENTER_Y : sh_cy;

    // Stage 1: centre-relative coordinates; coefficients travel with the
    // pixel so a frame boundary inside the pipeline never mixes frames.
    logic signed [DIFF_W-1:0]  s1_dx, s1_dy;
    logic signed [TRIG_W-1:0]  s1_cos, s1_sin;
    logic        [COORD_W-1:0] s1_cx, s1_cy;
    logic                      s1_fs;

    // Stage 2: the four rotation products
    logic signed [PROD_W-1:0]  s2_xc, s2_ys, s2_xs, s2_yc;
    logic        [COORD_W-1:0] s2_cx, s2_cy;
    logic                      s2_fs;

    // Stage 3 combinational: sums, rounding, range test, address
    logic signed [SUM_W-1:0] sx, sy, rx, ry;
    logic signed [XY_W-1:0]  x_c, y_c;
    int                      x_i, y_i, row_src;
    logic                    in_rng;
    logic [ADDR_W-1:0]       addr_c;

    always_comb begin
        sx      = SUM_W'(s2_xc) - SUM_W'(s2_ys);
        sy      = SUM_W'(s2_xs) + SUM_W'(s2_yc);
        rx      = (sx + SUM_W'(RND)) >>> FRAC_W;
        ry      = (sy + SUM_W'(RND)) >>> FRAC_W;
        x_c     = XY_W'(rx) + XY_W'($signed({1'b0, s2_cx}));
        y_c     = XY_W'(ry) + XY_W'($signed({1'b0, s2_cy}));
        x_i     = int'(x_c);
        y_i     = int'(y_c);
        in_rng  = (x_i >= 0) && (x_i < H_RES) && (y_i >= 0) && (y_i < V_RES);
        row_src = (FLIP_V != 0) ? (V_RES - 1 - y_i) : y_i;
        addr_c  = in_rng ? ADDR_W'(row_src * H_RES + x_i) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sh_cos           <= TRIG_W'(ONE);
            sh_sin           <= '0;
            sh_cx            <= COORD_W'(H_RES / 2);
            sh_cy            <= COORD_W'(V_RES / 2);
            vld_pipe         <= '0;
            s1_dx            <= '0;
            s1_dy            <= '0;
            s1_cos           <= '0;
            s1_sin           <= '0;
            s1_cx            <= '0;
            s1_cy            <= '0;
            s1_fs            <= 1'b0;
            s2_xc            <= '0;
            s2_ys            <= '0;
            s2_xs            <= '0;
            s2_yc            <= '0;
            s2_cx            <= '0;
            s2_cy            <= '0;
            s2_fs            <= 1'b0;
            bus.oVALID       <= 1'b0;
            bus.oADDR        <= '0;
            bus.oIN_RANGE    <= 1'b0;
            bus.oFRAME_START <= 1'b0;
        end else if (!stall) begin
            if (enter && first) begin
                sh_cos <= iCOS;
                sh_sin <= iSIN;
                sh_cx  <= iCENTER_X;
                sh_cy  <= iCENTER_Y;
            end
            vld_pipe <= {vld_pipe[STAGES-1:1], enter};

            s1_dx  <= $signed({1'b0, col}) - $signed({1'b0, cx_use});
            s1_dy  <= $signed({1'b0, row}) - $signed({1'b0, cy_use});
            s1_cos <= cos_use;
            s1_sin <= sin_use;
            s1_cx  <= cx_use;
            s1_cy  <= cy_use;
            s1_fs  <= first;

            s2_xc <= PROD_W'(s1_dx) * PROD_W'(s1_cos);
            s2_ys <= PROD_W'(s1_dy) * PROD_W'(s1_sin);
            s2_xs <= PROD_W'(s1_dx) * PROD_W'(s1_sin);
            s2_yc <= PROD_W'(s1_dy) * PROD_W'(s1_cos);
            s2_cx <= s1_cx;
            s2_cy <= s1_cy;
            s2_fs <= s1_fs;

            bus.oVALID       <= vld_pipe[STAGES-1];
            bus.oADDR        <= addr_c;
            bus.oIN_RANGE    <= in_rng;
            bus.oFRAME_START <= s2_fs;
        end
    end

    // The top valid bit is mirrored by oVALID, which is the real output flop
    logic unused_vld;
    assign unused_vld = vld_pipe[STAGES];

endmodule
